// File: rtl/spi_cfg_hub_if.sv
// Command/readback and SPI bus bundle for spi_cfg_hub.
// The master modport is the host side (command writer + SPI slave device model); slave is the hub.
interface spi_cfg_hub_if #(
  parameter int NUM_CH   = 4,
  parameter int MAX_BITS = 24
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W = $clog2(MAX_BITS + 1);

  logic                cfg_en;
  logic [CH_W-1:0]     cfg_ch;
  logic [LEN_W-1:0]    cfg_len;
  logic                cfg_rd;
  logic [MAX_BITS-1:0] cfg_data;
  logic                cfg_full;
  logic                cfg_drop;
  logic                busy;
  logic                rd_valid;
  logic [MAX_BITS-1:0] rd_data;
  logic [CH_W-1:0]     rd_ch;
  logic [NUM_CH-1:0]   spi_ncs;
  logic                spi_sclk;
  logic                spi_sdo;
  logic                spi_sdi;

  modport master (
    output cfg_en, cfg_ch, cfg_len, cfg_rd, cfg_data, spi_sdi,
    input  cfg_full, cfg_drop, busy, rd_valid, rd_data, rd_ch, spi_ncs, spi_sclk, spi_sdo
  );

  modport slave (
    input  cfg_en, cfg_ch, cfg_len, cfg_rd, cfg_data, spi_sdi,
    output cfg_full, cfg_drop, busy, rd_valid, rd_data, rd_ch, spi_ncs, spi_sclk, spi_sdo
  );
endinterface

// File: rtl/spi_cfg_hub.sv
// Multi-device SPI configuration master: queued commands, shared mode-0 bus, per-command
// word length and optional SDI readback.
module spi_cfg_hub #(
  parameter int NUM_CH     = 4,
  parameter int MAX_BITS   = 24,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  spi_cfg_hub_if.slave bus
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W   = $clog2(MAX_BITS + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                                : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BITS);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [LEN_W-1:0]    len;
    logic                rd;
    logic [MAX_BITS-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  cmd_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             drop_q;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    bit_q;
  logic [MAX_BITS-1:0] tx_q, rx_q;
  logic [CH_W-1:0]     ch_q;
  logic                rd_q;
  logic [NUM_CH-1:0]   ncs_q;
  logic                sclk_q, sdo_q;
  logic                rd_valid_q;
  logic [MAX_BITS-1:0] rd_data_q;
  logic [CH_W-1:0]     rd_ch_q;

  logic             full, push, pop, head_ok;
  cmd_t             head;
  logic [LEN_W-1:0] head_len;

  assign full     = (count_q == DEPTH);
  assign push     = bus.cfg_en && !full;
  assign head     = fifo_q[rd_ptr_q];
  assign head_ok  = (head.len != '0) && ({1'b0, head.ch} < CH_LIMIT);
  assign head_len = (head.len > MAX_LEN) ? MAX_LEN : head.len;
  // The last GAP cycle doubles as IDLE so back-to-back frames see exactly CLK_DIV deselected cycles.
  assign pop      = (count_q != '0) && ((state_q == IDLE) || (state_q == GAP && cnt_q == '0));

  // NOTE: the command storage has no reset; only pointers and count need one, which keeps it RAM-mappable.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{ch: bus.cfg_ch, len: bus.cfg_len, rd: bus.cfg_rd, data: bus.cfg_data};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= bus.cfg_en && full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ch_q       <= '0;
      rd_q       <= 1'b0;
      ncs_q      <= '1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: ;
        SETUP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[MAX_BITS-2:0], bus.spi_sdi};
            cnt_q   <= CNT_W'(CLK_DIV - 1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (sclk_q) begin
            sclk_q <= 1'b0;
            sdo_q  <= (bit_q != '0) ? tx_q[bit_q - 1'b1] : 1'b0;
            cnt_q  <= CNT_W'(CLK_DIV - 1);
          end else if (bit_q == '0) begin
            cnt_q   <= CNT_W'(CS_HOLD - 1);
            state_q <= HOLD;
          end else begin
            bit_q  <= bit_q - 1'b1;
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[MAX_BITS-2:0], bus.spi_sdi};
            cnt_q  <= CNT_W'(CLK_DIV - 1);
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ncs_q <= '1;
            sdo_q <= 1'b0;
            if (rd_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= rx_q;
              rd_ch_q    <= ch_q;
            end
            cnt_q   <= CNT_W'(CLK_DIV - 1);
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: this launch sits after the case on purpose; the later non-blocking assignment wins.
      if (pop && head_ok) begin
        ncs_q   <= ~(NUM_CH'(1) << head.ch);
        sdo_q   <= head.data[head_len - 1'b1];
        tx_q    <= head.data;
        bit_q   <= head_len - 1'b1;
        rx_q    <= '0;
        ch_q    <= head.ch;
        rd_q    <= head.rd;
        cnt_q   <= CNT_W'(CS_SETUP - 1);
        state_q <= SETUP;
      end
    end
  end

  assign bus.cfg_full = full;
  assign bus.cfg_drop = drop_q;
  assign bus.busy     = (count_q != '0) || (state_q != IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ch    = rd_ch_q;
  assign bus.spi_ncs  = ncs_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_sdo  = sdo_q;
endmodule

// File: tb/tb_spi_cfg_hub.sv
// Scoreboard bench for spi_cfg_hub: stimulus pushes expected frames/readbacks, bus monitors pop and compare.
// NUM_CH=5 so that CH=5 is an encodable but out-of-range index.
module tb_spi_cfg_hub;
  localparam int NCH = 5;
  localparam logic [NCH-1:0] ALL1 = '1;

  typedef struct {
    int          ch;
    int          len;
    logic [23:0] data;
    int          low;
    logic [23:0] sdi;
  } txn_t;

  typedef struct {
    logic [23:0] data;
    int          ch;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cfg_hub_if #(.NUM_CH(NCH), .MAX_BITS(24)) bus ();
  spi_cfg_hub #(.NUM_CH(NCH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int tests  = 0;
  int failed = 0;
  txn_t exp_txn_q[$];
  rd_t  exp_rd_q[$];

  // Monitor state
  logic           in_txn = 1'b0;
  logic [NCH-1:0] prev_ncs = '1;
  logic           prev_sclk = 1'b0;
  int             ncs_falls = 0, low_cnt = 0, rises = 0, cur_ch = 0, cur_len = 1, sdi_idx = 0;
  int             gap_cnt = 0, last_gap = 0, onehot_viol = 0, rd_valid_cnt = 0;
  logic [23:0]    sdo_word = '0, cur_sdi = '0;
  txn_t           mon_e;
  rd_t            mon_r;
  logic [NCH-1:0] rd_prev_ncs = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input int ch, input int len, input logic [23:0] data, input logic [23:0] sdi);
    txn_t t;
    t.ch   = ch;
    t.len  = len;
    t.data = data;
    t.low  = 2 + 2 * 4 * len + 2;
    t.sdi  = sdi;
    return t;
  endfunction

  // Frame monitor and SDI device model
  always @(negedge clk) begin
    if (rst) begin
      in_txn      = 1'b0;
      prev_ncs    = '1;
      prev_sclk   = 1'b0;
      bus.spi_sdi = 1'b0;
    end else begin
      int zeros;
      zeros = 0;
      for (int i = 0; i < NCH; i++) if (!bus.spi_ncs[i]) zeros++;
      if (zeros > 1) onehot_viol++;
      if (prev_ncs == ALL1 && bus.spi_ncs != ALL1) begin
        ncs_falls++;
        in_txn   = 1'b1;
        low_cnt  = 0;
        rises    = 0;
        sdo_word = '0;
        last_gap = gap_cnt;
        for (int i = 0; i < NCH; i++) if (!bus.spi_ncs[i]) cur_ch = i;
        if (exp_txn_q.size() > 0) begin
          cur_sdi = exp_txn_q[0].sdi;
          cur_len = exp_txn_q[0].len;
        end else begin
          cur_sdi = '0;
          cur_len = 1;
        end
        sdi_idx     = cur_len - 1;
        bus.spi_sdi = cur_sdi[sdi_idx];
      end
      if (bus.spi_ncs != ALL1) low_cnt++;
      if (in_txn && !prev_sclk && bus.spi_sclk) begin
        sdo_word = {sdo_word[22:0], bus.spi_sdo};
        rises++;
        if (sdi_idx > 0) sdi_idx--;
        bus.spi_sdi = cur_sdi[sdi_idx];
      end
      if (in_txn && bus.spi_ncs == ALL1) begin
        in_txn      = 1'b0;
        gap_cnt     = 1;
        bus.spi_sdi = 1'b0;
        if (exp_txn_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL txn_unexpected: frame on ch %0d with %0d bits, none expected", cur_ch, rises);
        end else begin
          mon_e = exp_txn_q.pop_front();
          check("txn_ch", cur_ch, mon_e.ch);
          check("txn_bits", rises, mon_e.len);
          check("txn_sdo", sdo_word, mon_e.data);
          check("txn_ncs_low", low_cnt, mon_e.low);
        end
      end else if (bus.spi_ncs == ALL1) begin
        gap_cnt++;
      end
      prev_ncs  = bus.spi_ncs;
      prev_sclk = bus.spi_sclk;
    end
  end

  // Readback monitor
  always @(negedge clk) begin
    if (rst) begin
      rd_prev_ncs = '1;
    end else begin
      if (bus.rd_valid) begin
        rd_valid_cnt++;
        if (exp_rd_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL rd_unexpected: rd_valid with data 0x%0h ch %0d", bus.rd_data, bus.rd_ch);
        end else begin
          mon_r = exp_rd_q.pop_front();
          check("rd_data", bus.rd_data, mon_r.data);
          check("rd_ch", bus.rd_ch, mon_r.ch);
          check("rd_at_ncs_rise", (rd_prev_ncs != ALL1) && (bus.spi_ncs == ALL1), 1);
        end
      end
      rd_prev_ncs = bus.spi_ncs;
    end
  end

  task automatic cfg_write(input int ch, input int len, input logic rd, input logic [23:0] data);
    @(negedge clk);
    bus.cfg_en   = 1'b1;
    bus.cfg_ch   = 3'(ch);
    bus.cfg_len  = 5'(len);
    bus.cfg_rd   = rd;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy && !in_txn) return;
    end
    tests++;
    failed++;
    $display("FAIL %s: still busy after %0d cycles", name, budget);
  endtask

  task automatic wait_falls(input string name, input int target, input int min_rises, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ncs_falls >= target && in_txn && rises >= min_rises) return;
    end
    tests++;
    failed++;
    $display("FAIL %s: frame progress not seen within %0d cycles", name, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bus.cfg_en   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_len  = '0;
    bus.cfg_rd   = 1'b0;
    bus.cfg_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ncs", bus.spi_ncs, ALL1);
    check("rst_sclk", bus.spi_sclk, 0);
    check("rst_sdo", bus.spi_sdo, 0);
    check("rst_full", bus.cfg_full, 0);
    check("rst_drop", bus.cfg_drop, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_ch", bus.rd_ch, 0);
    #2 rst = 1'b0;

    // Default 24-bit write, no readback; nCS falls one edge after the write
    exp_txn_q.push_back(mk(1, 24, 24'h801234, 24'h0));
    cfg_write(1, 24, 1'b0, 24'h801234);
    check("lat_ncs_still_high", bus.spi_ncs, ALL1);
    @(negedge clk);
    check("lat_ncs1_low", bus.spi_ncs, 5'b11101);
    wait_idle("default_idle", 1000);
    check("default_no_rd", rd_valid_cnt, 0);

    // 16-bit readback on CH2
    exp_txn_q.push_back(mk(2, 16, 24'h001234, 24'h00A55A));
    exp_rd_q.push_back('{data: 24'h00A55A, ch: 2});
    cfg_write(2, 16, 1'b1, 24'h001234);
    wait_idle("readback_idle", 1000);
    check("readback_count", rd_valid_cnt, 1);

    // RD=0 leaves the readback registers alone
    exp_txn_q.push_back(mk(0, 8, 24'h0000C3, 24'hFFFFFF));
    cfg_write(0, 8, 1'b0, 24'h0000C3);
    wait_idle("rd0_idle", 1000);
    check("rd0_keeps_data", bus.rd_data, 24'h00A55A);
    check("rd0_keeps_ch", bus.rd_ch, 2);

    // FIFO overflow while a long frame is on the bus
    f0 = ncs_falls;
    exp_txn_q.push_back(mk(3, 24, 24'hFEDCBA, 24'h0));
    cfg_write(3, 24, 1'b0, 24'hFEDCBA);
    wait_falls("ovf_first_frame", f0 + 1, 0, 50);
    for (int i = 0; i < 9; i++) begin
      bus.cfg_en   = 1'b1;
      bus.cfg_ch   = 3'(i % 4);
      bus.cfg_len  = 5'd8;
      bus.cfg_rd   = 1'b0;
      bus.cfg_data = 24'h10 + 24'(i);
      if (i < 8) exp_txn_q.push_back(mk(i % 4, 8, 24'h10 + 24'(i), 24'h0));
      @(negedge clk);
      check("ovf_full", bus.cfg_full, (i >= 7) ? 1 : 0);
      check("ovf_drop", bus.cfg_drop, (i == 8) ? 1 : 0);
    end
    bus.cfg_en = 1'b0;
    @(negedge clk);
    check("ovf_drop_pulse_end", bus.cfg_drop, 0);
    wait_idle("ovf_idle", 5000);
    check("ovf_frames", ncs_falls - f0, 9);
    check("ovf_full_after", bus.cfg_full, 0);

    // Invalid commands: LEN=0, CH=5, then LEN=30 clamps to 24
    f0 = ncs_falls;
    exp_txn_q.push_back(mk(0, 24, 24'h123456, 24'h0));
    cfg_write(0, 0, 1'b0, 24'hAAAAAA);
    cfg_write(5, 8, 1'b1, 24'h0000FF);
    cfg_write(0, 30, 1'b0, 24'h123456);
    wait_idle("invalid_idle", 1000);
    check("invalid_frames", ncs_falls - f0, 1);
    check("invalid_busy_low", bus.busy, 0);

    // Back-to-back CH0 then CH3: exactly CLK_DIV deselected cycles between them
    f0 = ncs_falls;
    exp_txn_q.push_back(mk(0, 8, 24'h00005A, 24'h0));
    exp_txn_q.push_back(mk(3, 8, 24'h0000A5, 24'h0));
    cfg_write(0, 8, 1'b0, 24'h00005A);
    cfg_write(3, 8, 1'b0, 24'h0000A5);
    wait_idle("b2b_idle", 1000);
    check("b2b_frames", ncs_falls - f0, 2);
    check("b2b_gap", last_gap, 4);

    // Async reset in the middle of bit 10 of a 16-bit readback frame, with a second command queued
    f0 = ncs_falls;
    cfg_write(1, 16, 1'b1, 24'h00BEEF);
    cfg_write(2, 8, 1'b0, 24'h000055);
    wait_falls("rst_mid_frame", f0 + 1, 10, 400);
    #2 rst = 1'b1;
    #1;
    check("arst_ncs", bus.spi_ncs, ALL1);
    check("arst_sclk", bus.spi_sclk, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_full", bus.cfg_full, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    f0 = ncs_falls;
    repeat (300) @(negedge clk);
    check("arst_no_frames", ncs_falls - f0, 0);
    check("arst_no_rd_valid", rd_valid_cnt, 1);
    check("arst_rd_data", bus.rd_data, 0);
    check("arst_busy_after", bus.busy, 0);

    // Global properties
    check("onehot_ncs", onehot_viol, 0);
    check("exp_txn_left", exp_txn_q.size(), 0);
    check("exp_rd_left", exp_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
